// File: rtl/vgpr_wr_port_arbiter.sv
// vgpr_wr_port_arbiter: LSU-priority, ALU round-robin arbiter for the VGPR write port with LSU burst limit
module vgpr_wr_port_arbiter #(
  parameter int NUM_ALU = 8,
  parameter int LSU_BURST_MAX = 4,
  parameter int SEL_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_ALU-1:0]   alu_wr_req,
  input  logic                 lsu_wr_req,
  output logic [SEL_WIDTH-1:0] rfa_select_fu,
  output logic                 grant_valid,
  output logic                 lsu_grant,
  output logic                 alu_forced
);
  localparam logic [2:0] BCNT_MAX = 3'(LSU_BURST_MAX);
  logic [2:0] ptr, bcnt, win, bcnt_nxt;
  logic found, lsu_win, alu_win;
  logic [SEL_WIDTH-1:0] sel_nxt;
  // first requesting ALU at or after ptr, wrapping mod 8
  always_comb begin
    logic [2:0] j;
    found = 1'b0;
    win = '0;
    j = '0;
    for (int k = 0; k < NUM_ALU; k++) begin
      j = ptr + k[2:0];
      if (!found && alu_wr_req[j]) begin
        found = 1'b1;
        win = j;
      end
    end
  end
  // LSU wins unless the burst limit is hit while an ALU waits
  always_comb begin
    lsu_win = lsu_wr_req && (!found || bcnt < BCNT_MAX);
    alu_win = found && !lsu_win;
    bcnt_nxt = lsu_win ? (found ? bcnt + 3'd1 : 3'd0) : alu_win ? 3'd0 : bcnt;
    sel_nxt = '0;
    if (lsu_win) sel_nxt[NUM_ALU] = 1'b1;
    else if (alu_win) sel_nxt[win] = 1'b1;
  end
  // register grant, round-robin pointer and burst counter
  always_ff @(posedge clk) begin
    if (rst) begin
      rfa_select_fu <= '0;
      grant_valid <= 1'b0;
      lsu_grant <= 1'b0;
      alu_forced <= 1'b0;
      ptr <= '0;
      bcnt <= '0;
    end else begin
      rfa_select_fu <= sel_nxt;
      grant_valid <= lsu_win || alu_win;
      lsu_grant <= lsu_win;
      alu_forced <= alu_win && lsu_wr_req;
      ptr <= alu_win ? win + 3'd1 : ptr;
      bcnt <= bcnt_nxt;
    end
  end
endmodule
